// File: rtl/tube_scan_decoder.sv
// Passive decoder for a multiplexed 4-digit seven-segment scan: rebuilds the
// displayed hex value, decimal points and per-digit pattern errors.
module tube_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  tube_select,
  input  logic [7:0]  tube_segment,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        value_changed,
  output logic        scan_lost
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);

  // Returns {err, nibble}; unknown patterns decode to nibble 0 with err set.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    case (pat)
      7'h3F: return 5'h00;
      7'h06: return 5'h01;
      7'h5B: return 5'h02;
      7'h4F: return 5'h03;
      7'h66: return 5'h04;
      7'h6D: return 5'h05;
      7'h7D: return 5'h06;
      7'h07: return 5'h07;
      7'h7F: return 5'h08;
      7'h6F: return 5'h09;
      7'h77: return 5'h0A;
      7'h7C: return 5'h0B;
      7'h39: return 5'h0C;
      7'h5E: return 5'h0D;
      7'h79: return 5'h0E;
      7'h71: return 5'h0F;
      default: return 5'h10;
    endcase
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] sel);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  logic [3:0]       sel_q, sel_d, prev_sel_q, prev_sel_d;
  logic [7:0]       seg_q, seg_d, prev_seg_q, prev_seg_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [3:0]       seen_q, seen_d;
  logic [15:0]      stg_nib_q, stg_nib_d;
  logic [3:0]       stg_dp_q, stg_dp_d, stg_err_q, stg_err_d;
  logic [15:0]      value_q, value_d;
  logic [3:0]       dp_q, dp_d, err_q, err_d;
  logic             fv_q, fv_d, vc_q, vc_d, lost_q, lost_d;

  logic             sample_valid, same, capture, frame_done, timeout_hit;
  logic [4:0]       decoded;
  logic [1:0]       idx;
  logic [3:0]       seen_all;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    sel_d      = SEL_ACTIVE_LOW ? ~tube_select : tube_select;
    seg_d      = SEG_ACTIVE_LOW ? ~tube_segment : tube_segment;
    prev_sel_d = sel_q;
    prev_seg_d = seg_q;

    sample_valid = (sel_q != 4'd0) && ((sel_q & (sel_q - 4'd1)) == 4'd0);
    same         = (sel_q == prev_sel_q) && (seg_q == prev_seg_q);

    if (!sample_valid)        run_d = '0;
    else if (!same)           run_d = RUN_W'(1);
    else if (run_q == RUN_MAX) run_d = RUN_MAX;
    else                      run_d = run_q + 1'b1;

    // Fires only on the step from STABLE_CYCLES-1, so long dwells capture once.
    capture = sample_valid && same && (run_q == RUN_MAX - 1'b1);
    decoded = decode_seg(seg_q[6:0]);
    idx     = onehot_idx(sel_q);

    stg_nib_d = stg_nib_q;
    stg_dp_d  = stg_dp_q;
    stg_err_d = stg_err_q;
    seen_all  = seen_q;
    if (capture) begin
      stg_nib_d[{idx, 2'b00} +: 4] = decoded[3:0];
      stg_dp_d[idx]                = seg_q[7];
      stg_err_d[idx]               = decoded[4];
      seen_all[idx]                = 1'b1;
    end
    frame_done = capture && (seen_all == 4'hF);

    if (capture)             to_d = '0;
    else if (to_q == TO_MAX) to_d = TO_MAX;
    else                     to_d = to_q + 1'b1;
    timeout_hit = !capture && (to_d == TO_MAX);

    seen_d = (frame_done || timeout_hit) ? 4'd0 : seen_all;

    value_d = value_q;
    dp_d    = dp_q;
    err_d   = err_q;
    if (frame_done) begin
      value_d = stg_nib_d;
      dp_d    = stg_dp_d;
      err_d   = stg_err_d;
    end
    fv_d = frame_done;
    vc_d = frame_done && (stg_nib_d != value_q);

    if (capture)          lost_d = 1'b0;
    else if (timeout_hit) lost_d = 1'b1;
    else                  lost_d = lost_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!reset) begin
      sel_q      <= '0;
      seg_q      <= '0;
      prev_sel_q <= '0;
      prev_seg_q <= '0;
      run_q      <= '0;
      to_q       <= '0;
      seen_q     <= '0;
      stg_nib_q  <= '0;
      stg_dp_q   <= '0;
      stg_err_q  <= '0;
      value_q    <= '0;
      dp_q       <= '0;
      err_q      <= '0;
      fv_q       <= 1'b0;
      vc_q       <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      seg_q      <= seg_d;
      prev_sel_q <= prev_sel_d;
      prev_seg_q <= prev_seg_d;
      run_q      <= run_d;
      to_q       <= to_d;
      seen_q     <= seen_d;
      stg_nib_q  <= stg_nib_d;
      stg_dp_q   <= stg_dp_d;
      stg_err_q  <= stg_err_d;
      value_q    <= value_d;
      dp_q       <= dp_d;
      err_q      <= err_d;
      fv_q       <= fv_d;
      vc_q       <= vc_d;
      lost_q     <= lost_d;
    end
  end

  assign value         = value_q;
  assign dp            = dp_q;
  assign digit_err     = err_q;
  assign frame_valid   = fv_q;
  assign value_changed = vc_q;
  assign scan_lost     = lost_q;

endmodule

// File: tb/tb_tube_scan_decoder.sv
// Bench for tube_scan_decoder: directed scans plus random scanning, compared
// every cycle against a history-based model of the display protocol.
`timescale 1ns/1ps
module tb_tube_scan_decoder;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  tube_select;
  logic [7:0]  tube_segment;
  logic [15:0] value;
  logic [3:0]  dp, digit_err;
  logic        frame_valid, value_changed, scan_lost;

  tube_scan_decoder #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .SEG_ACTIVE_LOW(1'b1),
    .SEL_ACTIVE_LOW(1'b0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tube_select  (tube_select),
    .tube_segment (tube_segment),
    .value        (value),
    .dp           (dp),
    .digit_err    (digit_err),
    .frame_valid  (frame_valid),
    .value_changed(value_changed),
    .scan_lost    (scan_lost)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] pat_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // ---------------- behavioural model ----------------
  logic [3:0]  h_sel [$];
  logic [7:0]  h_seg [$];
  int          edge_n = 0, last_evt = 0;
  logic [15:0] m_value;
  logic [3:0]  m_dp, m_err, m_seen;
  logic        m_fv, m_vc, m_lost;
  logic [3:0]  st_nib [4];
  logic        st_dp [4], st_err [4];
  bit          m_ready = 0;

  always @(posedge clk) begin
    int run, di;
    logic [3:0] s, nib;
    logic [7:0] g;
    logic [15:0] nv;
    logic e;
    edge_n++;
    m_fv = 1'b0;
    m_vc = 1'b0;
    if (!reset) begin
      m_value = '0; m_dp = '0; m_err = '0; m_seen = '0; m_lost = 1'b0;
      for (int i = 0; i < 4; i++) begin st_nib[i] = '0; st_dp[i] = 1'b0; st_err[i] = 1'b0; end
      h_sel.delete(); h_seg.delete();
      h_sel.push_back(4'd0); h_seg.push_back(8'd0);
      last_evt = edge_n;
    end else begin
      s = h_sel[h_sel.size()-1];
      g = h_seg[h_seg.size()-1];
      run = 0;
      for (int k = h_sel.size()-1; k >= 0; k--) begin
        if ($countones(h_sel[k]) != 1 || h_sel[k] != s || h_seg[k] != g) break;
        run++;
      end
      if (run == STABLE) begin
        di = 0;
        for (int i = 0; i < 4; i++) if (s[i]) di = i;
        nib = 4'd0; e = 1'b1;
        for (int v = 0; v < 16; v++) if (pat_tbl[v] == g[6:0]) begin nib = 4'(v); e = 1'b0; end
        st_nib[di] = nib; st_dp[di] = g[7]; st_err[di] = e;
        m_seen[di] = 1'b1;
        last_evt = edge_n;
        m_lost = 1'b0;
        if (m_seen == 4'hF) begin
          nv = {st_nib[3], st_nib[2], st_nib[1], st_nib[0]};
          m_vc = (nv != m_value);
          m_value = nv;
          m_dp  = {st_dp[3], st_dp[2], st_dp[1], st_dp[0]};
          m_err = {st_err[3], st_err[2], st_err[1], st_err[0]};
          m_fv = 1'b1;
          m_seen = '0;
        end
      end else if (edge_n - last_evt == TIMEOUT) begin
        m_lost = 1'b1;
        m_seen = '0;
      end
      h_sel.push_back(tube_select);
      h_seg.push_back(~tube_segment);
      while (h_sel.size() > STABLE + 1) begin
        void'(h_sel.pop_front());
        void'(h_seg.pop_front());
      end
    end
    m_ready = 1;
  end

  // Single compare process: all outputs against the model, every cycle.
  always @(negedge clk) begin
    if (m_ready)
      check("outputs{value,dp,err,fv,vc,lost}",
            {5'd0, value, dp, digit_err, frame_valid, value_changed, scan_lost},
            {5'd0, m_value, m_dp, m_err, m_fv, m_vc, m_lost});
  end

  int   fv_count = 0;
  logic last_vc = 1'b0;
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_count++;
      last_vc = value_changed;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [3:0] s, input logic [7:0] g, input int n);
    tube_select  = s;
    tube_segment = g;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] seg_raw(input logic [3:0] nib, input logic dpb);
    return ~{dpb, pat_tbl[nib]};
  endfunction

  task automatic show(input int d, input logic [3:0] nib, input logic dpb, input int n);
    drive(4'(1 << d), seg_raw(nib, dpb), n);
  endtask

  task automatic scan(input logic [15:0] v, input int dwell);
    for (int d = 3; d >= 0; d--) show(d, v[4*d +: 4], 1'b0, dwell);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fv0;
    reset = 1'b0;
    tube_select = 4'd0;
    tube_segment = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("reset value", {16'd0, value}, 32'd0);
    check("reset flags", {26'd0, dp, digit_err, frame_valid, value_changed, scan_lost}, 32'd0);
    reset = 1'b1;

    // Two clean scans of 0x1234: one frame each, change flagged only first time.
    fv0 = fv_count;
    scan(16'h1234, 8);
    drive(4'd0, 8'hFF, 2);
    check("first frame value", {16'd0, value}, 32'h1234);
    check("first frame vc", {31'd0, last_vc}, 32'd1);
    scan(16'h1234, 8);
    drive(4'd0, 8'hFF, 2);
    check("two frames", fv_count - fv0, 32'd2);
    check("repeat frame vc", {31'd0, last_vc}, 32'd0);

    // Short glitch on digit 2 showing 8 is shorter than the stability window.
    show(3, 4'h1, 1'b0, 8);
    show(2, 4'h8, 1'b0, 2);
    show(2, 4'h2, 1'b0, 8);
    show(1, 4'h3, 1'b0, 8);
    show(0, 4'h4, 1'b0, 8);
    drive(4'd0, 8'hFF, 2);
    check("glitch value", {16'd0, value}, 32'h1234);

    // Blank digit 1 and a lit decimal point on digit 0.
    show(3, 4'h1, 1'b0, 8);
    show(2, 4'h2, 1'b0, 8);
    drive(4'b0010, 8'hFF, 8);
    show(0, 4'h4, 1'b1, 8);
    drive(4'd0, 8'hFF, 2);
    check("blank value", {16'd0, value}, 32'h1204);
    check("blank err", {28'd0, digit_err}, 32'b0010);
    check("dp digit0", {28'd0, dp}, 32'b0001);

    // Multi-hot select held between dwells captures nothing.
    fv0 = fv_count;
    show(3, 4'h1, 1'b0, 8);
    show(2, 4'h2, 1'b0, 8);
    drive(4'b0011, seg_raw(4'h7, 1'b0), 20);
    show(1, 4'h3, 1'b0, 8);
    show(0, 4'h4, 1'b0, 8);
    drive(4'd0, 8'hFF, 2);
    check("multihot frames", fv_count - fv0, 32'd1);
    check("multihot value", {16'd0, value}, 32'h1234);

    // Scan stalls after two digits long enough to time out.
    show(3, 4'h9, 1'b0, 8);
    show(2, 4'h9, 1'b0, 8);
    drive(4'd0, 8'hFF, TIMEOUT + 100);
    check("lost asserted", {31'd0, scan_lost}, 32'd1);
    check("lost value held", {16'd0, value}, 32'h1234);
    // If seen were not cleared these two digits would complete a frame.
    fv0 = fv_count;
    show(1, 4'hE, 1'b0, 8);
    show(0, 4'hF, 1'b0, 8);
    check("no frame after lost", fv_count - fv0, 32'd0);
    scan(16'hBEEF, 8);
    drive(4'd0, 8'hFF, 2);
    check("beef value", {16'd0, value}, 32'hBEEF);
    check("beef vc", {31'd0, last_vc}, 32'd1);
    check("lost cleared", {31'd0, scan_lost}, 32'd0);

    // Reset mid-frame discards partial digits.
    show(3, 4'h5, 1'b0, 8);
    show(2, 4'hA, 1'b0, 8);
    show(1, 4'h5, 1'b0, 8);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midreset value", {16'd0, value}, 32'd0);
    check("midreset flags", {26'd0, dp, digit_err, frame_valid, value_changed, scan_lost}, 32'd0);
    fv0 = fv_count;
    show(0, 4'hA, 1'b0, 8);
    drive(4'd0, 8'hFF, 4);
    check("no frame after reset", fv_count - fv0, 32'd0);
    scan(16'h5A5A, 8);
    drive(4'd0, 8'hFF, 2);
    check("post reset frame", {16'd0, value}, 32'h5A5A);

    // Random scanning: digits, glitches, bad selects, bad patterns, resets.
    for (int it = 0; it < 400; it++) begin
      int kind;
      kind = $urandom_range(0, 99);
      if (kind < 70) begin
        show($urandom_range(0, 3), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             $urandom_range(1, 8));
      end else if (kind < 82) begin
        drive(4'(1 << $urandom_range(0, 3)), 8'($urandom), $urandom_range(1, 8));
      end else if (kind < 97) begin
        drive(4'($urandom_range(0, 15)), 8'($urandom), $urandom_range(1, 6));
      end else begin
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
    end
    drive(4'd0, 8'hFF, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tube_scan_decoder.md
Name: tube_scan_decoder

Overview:
- Receive-side counterpart of the CPU's multiplexed 4-digit seven-segment output; passively monitors tube_select/tube_segment.
- Reconstructs the displayed 16-bit hex value, the decimal-point bits and per-digit pattern errors.
- Used as a synthesizable checker in simulation benches and as an on-board loopback monitor; drives nothing back into the CPU.

Parameters:
- STABLE_CYCLES, 4: consecutive identical valid samples required to capture a digit (legal range >=2).
- TIMEOUT_CYCLES, 4096: cycles without any capture before scan_lost asserts.
- SEG_ACTIVE_LOW, 1: 1 = segment lit when its tube_segment bit is 0.
- SEL_ACTIVE_LOW, 0: 1 = digit selected when its tube_select bit is 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- tube_select  in  4  digit enables; bit i = digit i, bit 3 = most significant nibble.
- tube_segment  in  8  segments {dp,g,f,e,d,c,b,a}.
- value  out  16  last completed frame, digit i in value[4i+3:4i].
- dp  out  4  decimal-point state per digit, last completed frame.
- digit_err  out  4  per digit: segment pattern not in the hex table, last completed frame.
- frame_valid  out  1  one-cycle pulse when a new frame completes.
- value_changed  out  1  one-cycle pulse with frame_valid when value differs from the previous frame.
- scan_lost  out  1  level; no capture for TIMEOUT_CYCLES.

Behaviour:
- Reset (reset==0 at a rising edge): value=0, dp=0, digit_err=0, frame_valid=0, value_changed=0, scan_lost=0. All internal state cleared: sample regs, run counter, seen mask, staging regs, timeout counter. A reset mid-frame discards partial digits; no frame_valid results from pre-reset captures.
- Input stage: tube_select and tube_segment are registered every cycle, one cycle of latency. Polarity is normalized to active-high per parameter.
- Valid sample: normalized select is exactly one-hot. Zero-hot or multi-hot samples are invalid; an invalid sample resets the run counter to 0.
- Run counter: counts consecutive valid samples identical in {select, segment} to the previous sample. A differing valid sample restarts the counter at 1. The counter saturates at STABLE_CYCLES.
- Capture: on the edge where the counter reaches STABLE_CYCLES, exactly once per run:
  - staging nibble[i] <= decode(seg[6:0]);
  - staging dp[i] <= seg[7];
  - staging err[i] <= pattern not in table;
  - seen[i] <= 1.
  - A run held longer than STABLE_CYCLES does not recapture.
- Decode table (gfedcba, active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. Any other pattern gives nibble 0 and err=1. dp is ignored for decoding.
- Recapture of an already-seen digit before frame completion overwrites its staging entry; this is not an error.
- Frame completion: on the same edge that a capture makes seen==4'b1111:
  - value, dp and digit_err load from staging, including the capture occurring on that edge;
  - frame_valid=1 for one cycle;
  - value_changed=1 if the new value != the old value. The first frame after reset compares against 0.
  - seen clears to 0 on the same edge.
- Latency: a digit held stable from cycle t on the pins is captured at edge t+STABLE_CYCLES.
- Timeout: the counter increments every cycle and clears on any capture. When it reaches TIMEOUT_CYCLES: scan_lost=1 and seen clears. value/dp/digit_err hold. scan_lost deasserts on the next capture edge.
- Simultaneous events: a capture on the timeout edge wins; the counter clears and scan_lost stays 0.
- Counters must not wrap: the run counter saturates at STABLE_CYCLES, the timeout counter at TIMEOUT_CYCLES.

Test Plan:
- Scan 0x1234, each digit held 8 cycles, active-low segments, order 3,2,1,0 -> frame_valid pulses once per 32-cycle frame; value=0x1234, dp=0, digit_err=0; value_changed on the first frame only.
- Same scan with a 2-cycle glitch of digit 2 showing 0x7F (8) inserted before its real 8-cycle dwell, STABLE_CYCLES=4 -> glitch ignored; value=0x1234.
- Digit 1 segments blank (raw 0xFF active-low) -> value=0x1204, digit_err=4'b0010; digit 0 with dp lit -> dp=4'b0001.
- tube_select=4'b0011 held 20 cycles between dwells -> no capture during it; frame completes normally after.
- Scan stops after 2 digits for 4096 cycles -> scan_lost=1, value holds 0x1234, seen cleared. A subsequent full scan of 0xBEEF -> frame_valid with value=0xBEEF, value_changed=1, scan_lost back to 0.
- reset pulsed low for 1 cycle after 3 digits captured -> all outputs 0. The next 1 digit does not produce frame_valid; a full new scan does.
